ex_stage: RTL and testbench

Execute stage of the RV32I 5-stage pipeline, directly downstream of the decode stage and its ID/EX register. Selects forwarded operands, runs the ALU, resolves branches and jumps back to fetch, and holds the EX/MEM pipeline register that feeds the memory stage. An optional sequential shift-add multiplier stalls the pipeline while it runs.

---
 rtl/ex_stage_pkg.sv | 27 ++
 rtl/ex_stage_seq_mul.sv | 97 +++++++++
 rtl/ex_stage.sv | 155 +++++++++++++++
 tb/tb_ex_stage.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared constants and types for the RV32I execute stage
//
// Contents:
//   ALU_*      3-bit ALUControlE operation codes
//   FWD_*      2-bit ForwardAE/ForwardBE operand source selects
//   mulState_t sequential multiplier state encoding

package ex_stage_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mulState_t;

endpackage

// File: rtl/ex_stage_seq_mul.sv
// rtl/ex_stage_seq_mul.sv - 32-iteration shift-add multiplier for the execute stage
//
// Ports:
//   CLK      in   clock, rising edge
//   CLR      in   asynchronous active-low reset
//   start    in   a multiply instruction sits in EX
//   a, b     in   multiplicand / multiplier, sampled only when leaving IDLE
//   busy     out  stall request (IDLE with start, and every RUN cycle)
//   done     out  high for the single DONE cycle; product is final there
//   product  out  accumulator (low XLEN bits of a*b once done)

module seq_mul
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

    mulState_t       state, stateNext;
    logic [XLEN-1:0] acc, accNext;
    logic [XLEN-1:0] mcand, mcandNext;
    logic [XLEN-1:0] mplier, mplierNext;
    logic [CW-1:0]   count, countNext;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state  <= MUL_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            state  <= stateNext;
            acc    <= accNext;
            mcand  <= mcandNext;
            mplier <= mplierNext;
            count  <= countNext;
        end
    end

    always_comb begin
        stateNext  = state;
        accNext    = acc;
        mcandNext  = mcand;
        mplierNext = mplier;
        countNext  = count;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            MUL_IDLE: begin
                // Forwarded operands are only valid in this cycle, so latch them now.
                if (start) begin
                    busy       = 1'b1;
                    mcandNext  = a;
                    mplierNext = b;
                    accNext    = '0;
                    countNext  = '0;
                    stateNext  = MUL_RUN;
                end
            end
            MUL_RUN: begin
                busy = 1'b1;
                if (mplier[0]) begin
                    accNext = acc + mcand;
                end
                mcandNext  = mcand << 1;
                mplierNext = mplier >> 1;
                countNext  = count + 1'b1;
                if (count == LAST_ITER) begin
                    stateNext = MUL_DONE;
                end
            end
            MUL_DONE: begin
                // No start check here: the same instruction is still in EX.
                done      = 1'b1;
                stateNext = MUL_IDLE;
            end
            default: begin
                stateNext = MUL_IDLE;
            end
        endcase
    end

    assign product = acc;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - RV32I execute stage: forwarding, ALU, branch resolve, EX/MEM register
//
// Build option: EX_MUL_EN adds the sequential multiplier for ALU code 111;
// without it code 111 yields 0 and MulBusyE is tied low.
//
// Ports:
//   CLK, CLR                       clock; asynchronous active-low reset
//   RegWriteE..ALUControlE         ID/EX control
//   RD1E, RD2E, PCE, ImmExtE,
//   PCPlus4E, RdE                  ID/EX data
//   ForwardAE, ForwardBE, ResultW  forwarding selects and writeback value
//   PCSrcE, PCTargetE              fetch redirect (combinational)
//   MulBusyE                       stall request (combinational)
//   RegWriteM..RdM                 EX/MEM register outputs

module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1E,
    input  logic [XLEN-1:0] RD2E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RdE,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            MulBusyE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [4:0]      RdM
);

    logic [XLEN-1:0] srcA;
    logic [XLEN-1:0] srcB;
    logic [XLEN-1:0] writeDataE;
    logic [XLEN-1:0] aluResult;
    logic            zero;
    logic            mulBusy;

`ifdef EX_MUL_EN
    logic            mulStart;
    logic            mulDone;
    logic [XLEN-1:0] mulProduct;

    assign mulStart = (ALUControlE == ALU_MUL);

    seq_mul #(
        .XLEN(XLEN)
    ) uMul (
        .CLK     (CLK),
        .CLR     (CLR),
        .start   (mulStart),
        .a       (srcA),
        .b       (srcB),
        .busy    (mulBusy),
        .done    (mulDone),
        .product (mulProduct)
    );
`else
    assign mulBusy = 1'b0;
`endif

    always_comb begin
        srcA = RD1E;
        case (ForwardAE)
            FWD_WB:  srcA = ResultW;
            FWD_MEM: srcA = ALUResultM;
            default: srcA = RD1E;
        endcase
    end

    always_comb begin
        writeDataE = RD2E;
        case (ForwardBE)
            FWD_WB:  writeDataE = ResultW;
            FWD_MEM: writeDataE = ALUResultM;
            default: writeDataE = RD2E;
        endcase
    end

    assign srcB = ALUSrcE ? ImmExtE : writeDataE;

    always_comb begin
        aluResult = '0;
        case (ALUControlE)
            ALU_ADD: aluResult = srcA + srcB;
            ALU_SUB: aluResult = srcA - srcB;
            ALU_AND: aluResult = srcA & srcB;
            ALU_OR:  aluResult = srcA | srcB;
            ALU_SLT: aluResult = {{(XLEN-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
`ifdef EX_MUL_EN
            ALU_MUL: aluResult = mulDone ? mulProduct : '0;
`else
            ALU_MUL: aluResult = '0;
`endif
            default: aluResult = '0;
        endcase
    end

    assign zero = (aluResult == '0);

    // Combinational outputs are also forced low while CLR is asserted so that
    // a reset mid-multiply drops the stall request immediately.
    assign MulBusyE  = CLR & mulBusy;
    assign PCTargetE = CLR ? (PCE + ImmExtE) : '0;
    assign PCSrcE    = CLR & ~mulBusy & ((BranchE & zero) | JumpE);

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
        end else if (mulBusy) begin
            // Bubble while the multiplier holds the instruction in EX.
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
            RdM        <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            ALUResultM <= aluResult;
            WriteDataM <= writeDataE;
            PCPlus4M   <= PCPlus4E;
            RdM        <= RdE;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking scoreboard bench for ex_stage

module tb_ex_stage;

    logic        CLK = 1'b0;
    logic        CLR = 1'b0;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [31:0] ResultW;
    logic        PCSrcE, MulBusyE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RdM;

    ex_stage #(.XLEN(32)) dut (
        .CLK(CLK), .CLR(CLR),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
        .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .MulBusyE(MulBusyE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        regWrite;
        logic        memWrite;
        logic [1:0]  resultSrc;
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic [4:0]  rd;
        logic [31:0] pcPlus4;
    } exMem_t;

    exMem_t      sbQ[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] prevAluM = 32'd0;
    logic        expPcSrc;
    logic [31:0] expPcTarget;

    function automatic exMem_t sampleM();
        sampleM = {RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCPlus4M};
    endfunction

    function automatic logic [31:0] refAlu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000: return a + b;
            3'b001: return a - b;
            3'b010: return a & b;
            3'b011: return a | b;
            3'b101: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
            3'b111: return a * b;
`endif
            default: return 32'd0;
        endcase
    endfunction

    task automatic clearInputs();
        RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
        ResultSrcE = 0; ALUControlE = 0; RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0;
        PCPlus4E = 0; RdE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    // Model of the instruction currently driven into EX; queued for retirement.
    task automatic pushExpected();
        logic [31:0] a, wd, b, r;
        a  = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? prevAluM : RD1E;
        wd = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? prevAluM : RD2E;
        b  = ALUSrcE ? ImmExtE : wd;
        r  = refAlu(ALUControlE, a, b);
        expPcSrc    = (BranchE && (r == 32'd0)) || JumpE;
        expPcTarget = PCE + ImmExtE;
        sbQ.push_back({RegWriteE, MemWriteE, ResultSrcE, r, wd, RdE, PCPlus4E});
        prevAluM = r;
    endtask

    task automatic test_reset();
        RegWriteE = 1; JumpE = 1; RD1E = 32'hFFFF_FFFF; ALUControlE = 3'b111;
        PCE = 32'h100; ImmExtE = 32'h4; PCPlus4E = 32'h104; RdE = 5'd3;
        @(posedge CLK); #1;
        total++; if (sampleM() !== '0) begin bad++; $display("FAIL reset_exmem got=%h want=0", sampleM()); end
        total++; if (MulBusyE !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", MulBusyE); end
        total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL reset_pcsrc got=%b want=0", PCSrcE); end
        total++; if (PCTargetE !== 32'd0) begin bad++; $display("FAIL reset_target got=%h want=0", PCTargetE); end
        clearInputs();
        @(posedge CLK); #1;
        CLR = 1'b1;
        prevAluM = 32'd0;
    endtask

    task automatic test_add_forward();
        exMem_t exp, obs;
        logic [31:0] want;
        for (int i = 0; i < 4; i++) begin
            clearInputs();
            RegWriteE = 1; RdE = 5'(i + 1); PCPlus4E = 32'h200 + 32'(4 * i);
            case (i)
                0: begin RD1E = 7; ALUSrcE = 1; want = 32'd7; end
                1: begin RD1E = 5; ForwardAE = 2'b10; ImmExtE = 3; ALUSrcE = 1; want = 32'd10; end
                2: begin ForwardAE = 2'b01; ResultW = 32'h100; ForwardBE = 2'b10; RD2E = 32'hDEAD;
                         ALUControlE = 3'b001; want = 32'hF6; end
                default: begin RD1E = 32'hFFFF_FFFF; RD2E = 1; BranchE = 1; want = 32'd0; end
            endcase
            pushExpected();
            @(negedge CLK);
            total++;
            if ({PCSrcE, PCTargetE, MulBusyE} !== {expPcSrc, expPcTarget, 1'b0}) begin
                bad++; $display("FAIL add_fwd_comb[%0d] got=%h want=%h", i, {PCSrcE, PCTargetE, MulBusyE}, {expPcSrc, expPcTarget, 1'b0});
            end
            @(posedge CLK); #1;
            exp = sbQ.pop_front(); obs = sampleM();
            total++; if (obs !== exp) begin bad++; $display("FAIL add_fwd_exmem[%0d] got=%h want=%h", i, obs, exp); end
            total++; if (ALUResultM !== want) begin bad++; $display("FAIL add_fwd_result[%0d] got=%h want=%h", i, ALUResultM, want); end
        end
    endtask

    task automatic test_branch();
        exMem_t exp, obs;
        logic wantSrc;
        logic [31:0] wantTgt;
        for (int i = 0; i < 3; i++) begin
            clearInputs();
            case (i)
                0: begin BranchE = 1; RD1E = 32'h1234; RD2E = 32'h1234; ALUControlE = 3'b001;
                         PCE = 32'h100; ImmExtE = 32'hFFFF_FFF8; wantSrc = 1; wantTgt = 32'hF8; end
                1: begin BranchE = 1; RD1E = 32'h1234; RD2E = 32'h1235; ALUControlE = 3'b001;
                         PCE = 32'h8000_0000; ImmExtE = 32'h8000_0004; wantSrc = 0; wantTgt = 32'h4; end
                default: begin JumpE = 1; RegWriteE = 1; RD1E = 32'h40; ImmExtE = 32'h10; ALUSrcE = 1;
                         PCE = 32'h40; PCPlus4E = 32'h44; RdE = 5'd1; ResultSrcE = 2'b10;
                         wantSrc = 1; wantTgt = 32'h50; end
            endcase
            pushExpected();
            @(negedge CLK);
            total++; if (PCSrcE !== wantSrc) begin bad++; $display("FAIL branch_pcsrc[%0d] got=%b want=%b", i, PCSrcE, wantSrc); end
            total++; if (PCTargetE !== wantTgt) begin bad++; $display("FAIL branch_target[%0d] got=%h want=%h", i, PCTargetE, wantTgt); end
            @(posedge CLK); #1;
            exp = sbQ.pop_front(); obs = sampleM();
            total++; if (obs !== exp) begin bad++; $display("FAIL branch_exmem[%0d] got=%h want=%h", i, obs, exp); end
        end
    endtask

    task automatic test_slt();
        exMem_t exp, obs;
        logic [31:0] want;
        for (int i = 0; i < 8; i++) begin
            clearInputs();
            RegWriteE = 1; RdE = 5'd10;
            case (i)
                0: begin RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 3'b101; want = 32'd1; end
                1: begin RD1E = 32'hFFFF_FFFF; RD2E = 1; ALUControlE = 3'b001; want = 32'hFFFF_FFFE; end
                2: begin RD1E = 32'h8000_0000; RD2E = 32'h7FFF_FFFF; ALUControlE = 3'b101; want = 32'd1; end
                3: begin RD1E = 32'h7FFF_FFFF; RD2E = 32'h8000_0000; ALUControlE = 3'b101; want = 32'd0; end
                4: begin RD1E = 32'h1234; RD2E = 32'h5678; ALUControlE = 3'b100; want = 32'd0; end
                5: begin RD1E = 32'h1234; RD2E = 32'h5678; ALUControlE = 3'b110; want = 32'd0; end
                6: begin RD1E = 32'hF0F0; RD2E = 32'hFF00; ALUControlE = 3'b010; want = 32'hF000; end
                default: begin RD1E = 32'hF0F0; RD2E = 32'hFF00; ALUControlE = 3'b011; want = 32'hFFF0; end
            endcase
            pushExpected();
            @(posedge CLK); #1;
            exp = sbQ.pop_front(); obs = sampleM();
            total++; if (obs !== exp) begin bad++; $display("FAIL alu_exmem[%0d] got=%h want=%h", i, obs, exp); end
            total++; if (ALUResultM !== want) begin bad++; $display("FAIL alu_result[%0d] got=%h want=%h", i, ALUResultM, want); end
        end
    endtask

    task automatic test_back_to_back();
        exMem_t exp, obs;
        for (int i = 0; i < 32; i++) begin
            clearInputs();
            ALUControlE = 3'($urandom_range(0, 7));
`ifdef EX_MUL_EN
            if (ALUControlE == 3'b111) ALUControlE = 3'b000;
`endif
            RD1E = $urandom; RD2E = $urandom; ImmExtE = $urandom; PCE = $urandom;
            if ($urandom_range(0, 3) == 0) RD2E = RD1E;
            ResultW = $urandom; ALUSrcE = 1'($urandom_range(0, 1));
            ForwardAE = 2'($urandom_range(0, 3)); ForwardBE = 2'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1)); MemWriteE = 1'($urandom_range(0, 1));
            BranchE = 1'($urandom_range(0, 1)); JumpE = ($urandom_range(0, 7) == 0);
            ResultSrcE = 2'($urandom_range(0, 3)); RdE = 5'($urandom_range(0, 31)); PCPlus4E = $urandom;
            pushExpected();
            @(negedge CLK);
            total++;
            if ({PCSrcE, PCTargetE, MulBusyE} !== {expPcSrc, expPcTarget, 1'b0}) begin
                bad++; $display("FAIL b2b_comb[%0d] got=%h want=%h", i, {PCSrcE, PCTargetE, MulBusyE}, {expPcSrc, expPcTarget, 1'b0});
            end
            @(posedge CLK); #1;
            exp = sbQ.pop_front(); obs = sampleM();
            total++; if (obs !== exp) begin bad++; $display("FAIL b2b_exmem[%0d] got=%h want=%h", i, obs, exp); end
        end
    endtask

`ifdef EX_MUL_EN
    task automatic test_mul();
        exMem_t exp, obs;
        logic [31:0] want;
        int busyCount;
        for (int i = 0; i < 2; i++) begin
            clearInputs();
            ALUControlE = 3'b111; PCPlus4E = 32'h300 + 32'(4 * i); RdE = 5'(7 + i);
            if (i == 0) begin
                RD1E = 32'h0001_0003; RD2E = 32'h0002_0005; RegWriteE = 1; want = 32'h000B_000F;
            end else begin
                // Operand A forwarded from the previous mul result; ALUResultM goes to 0 once busy.
                ForwardAE = 2'b10; RD1E = 32'hDEAD_BEEF; RD2E = 32'd3; MemWriteE = 1; JumpE = 1;
                want = 32'h0021_002D;
            end
            pushExpected();
            busyCount = 0;
            for (int c = 0; c < 40; c++) begin
                @(negedge CLK);
                if (!MulBusyE) break;
                busyCount++;
                total++; if (PCSrcE !== 1'b0) begin bad++; $display("FAIL mul_pcsrc_busy[%0d] got=%b want=0", i, PCSrcE); end
                @(posedge CLK); #1;
                total++; if (sampleM() !== '0) begin bad++; $display("FAIL mul_bubble[%0d] got=%h want=0", i, sampleM()); end
            end
            total++; if (busyCount !== 33) begin bad++; $display("FAIL mul_busy_cycles[%0d] got=%0d want=33", i, busyCount); end
            total++;
            if ({PCSrcE, PCTargetE} !== {expPcSrc, expPcTarget}) begin
                bad++; $display("FAIL mul_done_comb[%0d] got=%h want=%h", i, {PCSrcE, PCTargetE}, {expPcSrc, expPcTarget});
            end
            @(posedge CLK); #1;
            exp = sbQ.pop_front(); obs = sampleM();
            total++; if (obs !== exp) begin bad++; $display("FAIL mul_exmem[%0d] got=%h want=%h", i, obs, exp); end
            total++; if (ALUResultM !== want) begin bad++; $display("FAIL mul_result[%0d] got=%h want=%h", i, ALUResultM, want); end
            clearInputs();
        end
    endtask

    task automatic test_mul_reset();
        exMem_t exp, obs;
        int busyCount;
        clearInputs();
        ALUControlE = 3'b111; RD1E = 32'h1234; RD2E = 32'h10; RegWriteE = 1; RdE = 5'd9; PCPlus4E = 32'h404;
        for (int k = 0; k < 10; k++) begin
            @(posedge CLK); #1;
        end
        total++; if (MulBusyE !== 1'b1) begin bad++; $display("FAIL mulrst_busy_before got=%b want=1", MulBusyE); end
        CLR = 1'b0;
        #1;
        total++; if (MulBusyE !== 1'b0) begin bad++; $display("FAIL mulrst_busy got=%b want=0", MulBusyE); end
        total++; if ({PCSrcE, PCTargetE} !== 33'd0) begin bad++; $display("FAIL mulrst_comb got=%h want=0", {PCSrcE, PCTargetE}); end
        total++; if (sampleM() !== '0) begin bad++; $display("FAIL mulrst_exmem got=%h want=0", sampleM()); end
        @(posedge CLK); #1;
        total++; if (sampleM() !== '0) begin bad++; $display("FAIL mulrst_exmem_held got=%h want=0", sampleM()); end
        CLR = 1'b1;
        prevAluM = 32'd0;
        pushExpected();
        busyCount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (!MulBusyE) break;
            busyCount++;
            @(posedge CLK); #1;
        end
        total++; if (busyCount !== 33) begin bad++; $display("FAIL mulrst_restart_cycles got=%0d want=33", busyCount); end
        @(posedge CLK); #1;
        exp = sbQ.pop_front(); obs = sampleM();
        total++; if (obs !== exp) begin bad++; $display("FAIL mulrst_exmem_final got=%h want=%h", obs, exp); end
        total++; if (ALUResultM !== 32'h0001_2340) begin bad++; $display("FAIL mulrst_result got=%h want=00012340", ALUResultM); end
        clearInputs();
    endtask
`else
    task automatic test_mul_disabled();
        exMem_t exp, obs;
        clearInputs();
        ALUControlE = 3'b111; RD1E = 32'd6; RD2E = 32'd7; RegWriteE = 1; RdE = 5'd4; PCPlus4E = 32'h504;
        pushExpected();
        @(negedge CLK);
        total++; if (MulBusyE !== 1'b0) begin bad++; $display("FAIL nomul_busy got=%b want=0", MulBusyE); end
        @(posedge CLK); #1;
        exp = sbQ.pop_front(); obs = sampleM();
        total++; if (obs !== exp) begin bad++; $display("FAIL nomul_exmem got=%h want=%h", obs, exp); end
        total++; if (ALUResultM !== 32'd0) begin bad++; $display("FAIL nomul_result got=%h want=0", ALUResultM); end
        total++; if (RegWriteM !== 1'b1) begin bad++; $display("FAIL nomul_regwrite got=%b want=1", RegWriteM); end
        clearInputs();
    endtask
`endif

    initial begin
        clearInputs();
        test_reset();
        test_add_forward();
        test_branch();
        test_slt();
        test_back_to_back();
`ifdef EX_MUL_EN
        test_mul();
        test_mul_reset();
`else
        test_mul_disabled();
`endif
        total++;
        if (sbQ.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d want=0", sbQ.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
